scratchpad_mem_responder: RTL and testbench

- Memory-side responder for the scratchpad's external load/store port; serves sLoad/sStore requests and returns load_data with sLoad_hit or acknowledges with sStore_hit.
- Sits between the scratchpad and the DRAM model or memory subsystem, with a word-organised backing store and a programmable fixed access latency.
- Also used as the standard memory model in scratchpad top-level benches, preloaded through a debug write port.

---
 rtl/scratchpad_mem_if.sv | 24 ++
 rtl/scratchpad_mem_responder.sv | 122 ++++++++++++
 tb/tb_scratchpad_mem_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/scratchpad_mem_if.sv
// Load/store handshake between the scratchpad and its memory-side responder.
interface scratchpad_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              sLoad;
  logic [ADDR_W-1:0] load_addr;
  logic              sStore;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] load_data;
  logic              sLoad_hit;
  logic              sStore_hit;

  modport master (
    output sLoad, load_addr, sStore, store_addr, store_data,
    input  load_data, sLoad_hit, sStore_hit
  );

  modport slave (
    input  sLoad, load_addr, sStore, store_addr, store_data,
    output load_data, sLoad_hit, sStore_hit
  );
endinterface

// File: rtl/scratchpad_mem_responder.sv
// Fixed-latency word memory answering scratchpad loads/stores, with a backdoor
// write port for preloading.
//
// state | meaning
// IDLE  | sampling sStore (priority) then sLoad
// WAIT  | latency countdown; access performed when cnt reaches 0
// RESP  | one-cycle hit pulse, completion counter bump
module scratchpad_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int LAT    = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  scratchpad_mem_if.slave          bus,
  input  logic                     dbg_wen,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  input  logic [DATA_W-1:0]        dbg_wdata,
  output logic                     busy,
  output logic                     protocol_err,
  output logic [15:0]              load_count,
  output logic [15:0]              store_count
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF   = $clog2(DATA_W / 8);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OP_LOAD, OP_STORE} op_t;

  state_t            state, state_nxt;
  op_t               op;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] load_data_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              take_store, take_load, done;

  // Only the word-index bits of the byte addresses matter; the rest alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.load_addr, bus.store_addr};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_store = 1'b0;
    take_load  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sStore) begin
          take_store = 1'b1;
          state_nxt  = WAIT;
        end else if (bus.sLoad) begin
          take_load = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op           <= OP_LOAD;
      cnt          <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      load_data_q  <= '0;
      protocol_err <= 1'b0;
      load_count   <= '0;
      store_count  <= '0;
    end else begin
      if (take_store) begin
        op     <= OP_STORE;
        idx_q  <= bus.store_addr[OFF +: IDX_W];
        data_q <= bus.store_data;
        cnt    <= CNT_INIT;
      end else if (take_load) begin
        op    <= OP_LOAD;
        idx_q <= bus.load_addr[OFF +: IDX_W];
        cnt   <= CNT_INIT;
      end
      if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        // Requester must hold its request until the hit; a drop is sticky.
        if ((op == OP_LOAD && !bus.sLoad) || (op == OP_STORE && !bus.sStore))
          protocol_err <= 1'b1;
        if (done && op == OP_LOAD) load_data_q <= mem[idx_q];
      end
      if (state == RESP) begin
        if (op == OP_LOAD) load_count  <= load_count + 16'd1;
        else               store_count <= store_count + 16'd1;
      end
    end
  end

  // Store commit is written last so it overrides a same-word backdoor write.
  always_ff @(posedge CLK) begin
    if (dbg_wen) mem[dbg_addr] <= dbg_wdata;
    if (done && op == OP_STORE) mem[idx_q] <= data_q;
  end

  assign bus.load_data  = load_data_q;
  assign bus.sLoad_hit  = (state == RESP) && (op == OP_LOAD);
  assign bus.sStore_hit = (state == RESP) && (op == OP_STORE);
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_scratchpad_mem_responder.sv
// Scoreboard bench: drivers push expected hits (kind, data, cycle) from a
// word-array model; a negedge monitor pops and compares on every hit.
module tb_scratchpad_mem_responder;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 256;
  localparam int LAT    = 4;
  localparam int IDX_W  = 8;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              dbg_wen = 1'b0;
  logic [IDX_W-1:0]  dbg_addr = '0;
  logic [DATA_W-1:0] dbg_wdata = '0;
  logic              busy, protocol_err;
  logic [15:0]       load_count, store_count;

  scratchpad_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  scratchpad_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus),
    .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .busy(busy), .protocol_err(protocol_err),
    .load_count(load_count), .store_count(store_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_load;
    logic [63:0] data;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mem_m [DEPTH];
  int          m_ld = 0, m_st = 0;
  bit          m_err = 1'b0;
  int          checks = 0, errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int widx(logic [31:0] a);
    return int'(a[10:3]);
  endfunction

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (bus.sLoad_hit || bus.sStore_hit) begin
      if (sb.size() == 0) begin
        chk("unexpected_hit", {62'd0, bus.sLoad_hit, bus.sStore_hit}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hit_kind", {62'd0, bus.sLoad_hit, bus.sStore_hit}, e.is_load ? 64'd2 : 64'd1);
        chk("hit_cycle", 64'(cyc), 64'(e.at));
        if (e.is_load) chk("load_data", bus.load_data, e.data);
      end
    end
    if (sb.size() > 0 && sb[0].at < cyc) begin
      chk("hit_missing_cycle", 64'(cyc), 64'(sb[0].at));
      void'(sb.pop_front());
    end
  end

  task automatic dbg_write(int a, logic [63:0] d);
    dbg_wen = 1'b1; dbg_addr = IDX_W'(a); dbg_wdata = d;
    @(posedge CLK); #1;
    dbg_wen = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic check_counts();
    chk("load_count", {48'd0, load_count}, 64'(m_ld & 16'hFFFF));
    chk("store_count", {48'd0, store_count}, 64'(m_st & 16'hFFFF));
    chk("protocol_err", {63'd0, protocol_err}, {63'd0, m_err});
  endtask

  // Entered with the DUT idle; store captured on the next edge, a paired load
  // captured LAT+2 edges later.
  task automatic xact(bit do_st, logic [31:0] sa, logic [63:0] sd, bit do_ld, logic [31:0] la);
    int budget;
    int base;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    base = cyc;
    if (do_st) begin
      sb.push_back('{is_load: 1'b0, data: 64'd0, at: base + 1 + LAT});
      mem_m[widx(sa)] = sd;
    end
    if (do_ld)
      sb.push_back('{is_load: 1'b1, data: mem_m[widx(la)],
                     at: do_st ? base + 3 + 2 * LAT : base + 1 + LAT});
    bus.sStore = do_st; bus.store_addr = sa; bus.store_data = sd;
    bus.sLoad = do_ld; bus.load_addr = la;
    @(posedge CLK); #1;
    chk("busy_after_capture", {63'd0, busy}, 64'd1);
    if (do_st) begin
      bus.store_addr = $urandom; bus.store_data = {$urandom, $urandom};
    end else begin
      bus.load_addr = $urandom;
    end
    budget = 0;
    while ((bus.sStore || bus.sLoad) && budget < 4 * LAT + 16) begin
      if (bus.sStore_hit) bus.sStore = 1'b0;
      if (bus.sLoad_hit) bus.sLoad = 1'b0;
      if (bus.sStore || bus.sLoad) begin
        @(posedge CLK); #1;
        budget++;
      end
    end
    if (bus.sStore || bus.sLoad) begin
      chk("xact_timeout", 64'(budget), 64'd0);
      bus.sStore = 1'b0; bus.sLoad = 1'b0;
    end
    if (do_st) m_st++;
    if (do_ld) m_ld++;
    @(posedge CLK); #1;
    check_counts();
  endtask

  task automatic drop_load(logic [31:0] la);
    int budget;
    int base;
    base = cyc;
    sb.push_back('{is_load: 1'b1, data: mem_m[widx(la)], at: base + 1 + LAT});
    bus.sLoad = 1'b1; bus.load_addr = la;
    repeat (3) @(posedge CLK);
    #1;
    bus.sLoad = 1'b0;
    budget = 0;
    while (!bus.sLoad_hit && budget < 4 * LAT + 16) begin
      @(posedge CLK); #1;
      budget++;
    end
    chk("drop_hit_seen", {63'd0, bus.sLoad_hit}, 64'd1);
    m_ld++;
    m_err = 1'b1;
    @(posedge CLK); #1;
    check_counts();
  endtask

  initial begin
    bus.sLoad = 1'b0; bus.sStore = 1'b0;
    bus.load_addr = '0; bus.store_addr = '0; bus.store_data = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_load_data", bus.load_data, 64'd0);
    chk("rst_hits", {62'd0, bus.sLoad_hit, bus.sStore_hit}, 64'd0);
    check_counts();
    nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < DEPTH; i++) dbg_write(i, {$urandom, $urandom});

    dbg_write(3, 64'h1111_2222_3333_4444);
    xact(1'b0, 32'h0, 64'h0, 1'b1, 32'h18);

    xact(1'b1, 32'h40, 64'hDEAD_BEEF_0000_0001, 1'b0, 32'h0);
    xact(1'b0, 32'h0, 64'h0, 1'b1, 32'h40);

    xact(1'b1, 32'h100, 64'h0123_4567_89AB_CDEF, 1'b1, 32'h108);
    xact(1'b1, 32'h208, 64'hCAFE_F00D_1234_5678, 1'b1, 32'h208);

    xact(1'b1, 32'h800, 64'hA1A5_0000_FFFF_5A5A, 1'b0, 32'h0);
    xact(1'b0, 32'h0, 64'h0, 1'b1, 32'h0);

    drop_load(32'h18);
    xact(1'b0, 32'h0, 64'h0, 1'b1, 32'h40);
    xact(1'b1, 32'h48, 64'h5555_6666_7777_8888, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(2, 0));
      if ($urandom_range(3, 0) == 0) dbg_write(int'($urandom_range(DEPTH - 1, 0)), {$urandom, $urandom});
      xact(op != 0, $urandom, {$urandom, $urandom}, op != 1, $urandom);
    end

    dbg_write(5, 64'hAA);
    bus.sStore = 1'b1; bus.store_addr = 32'h28; bus.store_data = 64'hFFFF_0000_FFFF_0000;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    bus.sStore = 1'b0;
    m_ld = 0; m_st = 0; m_err = 1'b0;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_hits", {62'd0, bus.sLoad_hit, bus.sStore_hit}, 64'd0);
    chk("rst_mid_load_data", bus.load_data, 64'd0);
    check_counts();
    repeat (LAT + 3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    xact(1'b0, 32'h0, 64'h0, 1'b1, 32'h28);

    repeat (LAT + 4) @(posedge CLK);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
